// File: rtl/config_frame_mem_pkg.sv
// Shared types and bit-mapping helpers for the configuration frame memory.
// Config bit i lives in frame (N-1-i)/W at position W-1-((N-1-i)%W).
package config_frame_mem_pkg;

    typedef enum logic {
        RB_IDLE  = 1'b0,
        RB_VALID = 1'b1
    } rbState_t;

    function automatic int used_frames(input int noConfigBits, input int frameBits);
        return (noConfigBits + frameBits - 1) / frameBits;
    endfunction

    function automatic int bitFrame(input int i, input int noConfigBits, input int frameBits);
        return (noConfigBits - 1 - i) / frameBits;
    endfunction

    function automatic int bitPos(input int i, input int noConfigBits, input int frameBits);
        return frameBits - 1 - ((noConfigBits - 1 - i) % frameBits);
    endfunction

    // Number of config bits held by frame f; they occupy the top positions.
    function automatic int mappedBits(input int f, input int noConfigBits, input int frameBits);
        int rem;
        rem = noConfigBits - f * frameBits;
        return (rem < frameBits) ? rem : frameBits;
    endfunction

endpackage

// File: rtl/config_frame_slice.sv
// One frame: parity-checked shadow write, active copy on commit (1-cycle latency).
// No backpressure; writes with bad parity are dropped and flagged via parityBad.
module config_frame_slice
    import config_frame_mem_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 12,
    parameter int FrameIdx        = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [FrameBitsPerRow-1:0] frameData,
    input  logic                       frameParity,
    input  logic                       wrSel,
    input  logic                       commit,
    output logic                       parityBad,
    output logic [FrameBitsPerRow-1:0] shadowFrame,
    output logic [FrameBitsPerRow-1:0] activeFrame
);

    localparam int NBits = mappedBits(FrameIdx, NoConfigBits, FrameBitsPerRow);
    localparam logic [FrameBitsPerRow-1:0] Mask =
        {FrameBitsPerRow{1'b1}} << (FrameBitsPerRow - NBits);

    logic parityOk;

    assign parityOk  = ((^frameData) == frameParity);
    assign parityBad = wrSel && !parityOk;

    // Commit reads the pre-write shadow when both happen in one cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shadowFrame <= '0;
            activeFrame <= '0;
        end else begin
            if (wrSel && parityOk)
                shadowFrame <= frameData & Mask;
            if (commit)
                activeFrame <= shadowFrame;
        end
    end

endmodule

// File: rtl/config_frame_mem.sv
// Frame-addressed shadow/active config store with sticky errors and readback; commit visible next cycle.
// Readback holds RbValid/RbData until RbReady; frame writes never stall.
module config_frame_mem
    import config_frame_mem_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 12,
    localparam int SelW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    input  logic                       FrameParity,
    input  logic                       Commit,
    input  logic                       ClrErr,
    input  logic                       RbReq,
    input  logic [SelW-1:0]            RbSel,
    input  logic                       RbReady,
    output logic                       RbValid,
    output logic [FrameBitsPerRow-1:0] RbData,
    output logic [NoConfigBits-1:0]    ConfigBits,
    output logic [NoConfigBits-1:0]    ConfigBits_N,
    output logic                       ParityErr,
    output logic                       StrobeErr
);

    localparam int UsedFrames = used_frames(NoConfigBits, FrameBitsPerRow);

    logic                                  strobeOneHot;
    logic                                  strobeMulti;
    logic                                  commitEn;
    logic [UsedFrames-1:0]                 parityBad;
    logic [UsedFrames*FrameBitsPerRow-1:0] shadowFlat;
    logic [UsedFrames*FrameBitsPerRow-1:0] activeFlat;
    logic [FrameBitsPerRow-1:0]            rbFrame;
    rbState_t                              rbState;

    assign strobeOneHot = (FrameStrobe != '0) &&
                          ((FrameStrobe & (FrameStrobe - MaxFramesPerCol'(1))) == '0);
    assign strobeMulti  = (FrameStrobe != '0) && !strobeOneHot;
    assign commitEn     = Commit && !ParityErr && !StrobeErr;

    for (genvar f = 0; f < UsedFrames; f++) begin : gSlice
        config_frame_slice #(
            .FrameBitsPerRow(FrameBitsPerRow),
            .NoConfigBits   (NoConfigBits),
            .FrameIdx       (f)
        ) uSlice (
            .CLK        (CLK),
            .RST        (RST),
            .frameData  (FrameData),
            .frameParity(FrameParity),
            .wrSel      (strobeOneHot && FrameStrobe[f]),
            .commit     (commitEn),
            .parityBad  (parityBad[f]),
            .shadowFrame(shadowFlat[f*FrameBitsPerRow +: FrameBitsPerRow]),
            .activeFrame(activeFlat[f*FrameBitsPerRow +: FrameBitsPerRow])
        );
    end

    for (genvar i = 0; i < NoConfigBits; i++) begin : gMap
        localparam int F = bitFrame(i, NoConfigBits, FrameBitsPerRow);
        localparam int P = bitPos(i, NoConfigBits, FrameBitsPerRow);
        assign ConfigBits[i] = activeFlat[F*FrameBitsPerRow + P];
    end

    assign ConfigBits_N = ~ConfigBits;

    // A new error event outranks a same-cycle clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ParityErr <= 1'b0;
            StrobeErr <= 1'b0;
        end else begin
            if (|parityBad)
                ParityErr <= 1'b1;
            else if (ClrErr)
                ParityErr <= 1'b0;
            if (strobeMulti)
                StrobeErr <= 1'b1;
            else if (ClrErr)
                StrobeErr <= 1'b0;
        end
    end

    always_comb begin
        rbFrame = '0;
        for (int f = 0; f < UsedFrames; f++) begin
            if (RbSel == SelW'(f))
                rbFrame = shadowFlat[f*FrameBitsPerRow +: FrameBitsPerRow];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rbState <= RB_IDLE;
            RbValid <= 1'b0;
            RbData  <= '0;
        end else begin
            case (rbState)
                RB_IDLE: begin
                    if (RbReq) begin
                        rbState <= RB_VALID;
                        RbValid <= 1'b1;
                        RbData  <= rbFrame;
                    end
                end
                RB_VALID: begin
                    if (RbReady) begin
                        rbState <= RB_IDLE;
                        RbValid <= 1'b0;
                    end
                end
                default: begin
                    rbState <= RB_IDLE;
                    RbValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_frame_mem.sv
// Directed checks of frame write, commit, sticky errors and readback at default parameters.
module tb_config_frame_mem;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic        FrameParity;
    logic        Commit;
    logic        ClrErr;
    logic        RbReq;
    logic [4:0]  RbSel;
    logic        RbReady;
    logic        RbValid;
    logic [31:0] RbData;
    logic [11:0] ConfigBits;
    logic [11:0] ConfigBits_N;
    logic        ParityErr;
    logic        StrobeErr;

    int checks = 0;
    int errors = 0;

    config_frame_mem dut (
        .CLK         (CLK),
        .RST         (RST),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .FrameParity (FrameParity),
        .Commit      (Commit),
        .ClrErr      (ClrErr),
        .RbReq       (RbReq),
        .RbSel       (RbSel),
        .RbReady     (RbReady),
        .RbValid     (RbValid),
        .RbData      (RbData),
        .ConfigBits  (ConfigBits),
        .ConfigBits_N(ConfigBits_N),
        .ParityErr   (ParityErr),
        .StrobeErr   (StrobeErr)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idleInputs();
        RST = 0; FrameData = '0; FrameStrobe = '0; FrameParity = 0;
        Commit = 0; ClrErr = 0; RbReq = 0; RbSel = '0; RbReady = 0;
    endtask

    task automatic doReset();
        idleInputs();
        RST = 1;
        tick();
        RST = 0;
    endtask

    task automatic test_reset();
        idleInputs();
        RST = 1;
        tick(); tick();
        RST = 0;
        checks++; if (ConfigBits !== 12'h000) begin errors++; $display("FAIL reset_cfg: got %h want 000", ConfigBits); end
        checks++; if (ConfigBits_N !== 12'hFFF) begin errors++; $display("FAIL reset_cfgn: got %h want fff", ConfigBits_N); end
        checks++; if (ParityErr !== 1'b0 || StrobeErr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b%b want 00", ParityErr, StrobeErr); end
        checks++; if (RbValid !== 1'b0 || RbData !== 32'h0) begin errors++; $display("FAIL reset_rb: got %b %h want 0 0", RbValid, RbData); end
    endtask

    task automatic test_write_commit();
        FrameData = 32'hFFF0_0000; FrameParity = 0; FrameStrobe = 20'h00001;
        tick();
        FrameStrobe = '0;
        checks++; if (ConfigBits !== 12'h000) begin errors++; $display("FAIL write_no_commit: got %h want 000", ConfigBits); end
        Commit = 1;
        tick();
        Commit = 0;
        checks++; if (ConfigBits !== 12'hFFF) begin errors++; $display("FAIL commit_cfg: got %h want fff", ConfigBits); end
        checks++; if (ConfigBits_N !== 12'h000) begin errors++; $display("FAIL commit_cfgn: got %h want 000", ConfigBits_N); end
    endtask

    task automatic test_parity();
        doReset();
        FrameData = 32'h0010_0000; FrameParity = 0; FrameStrobe = 20'h00001;
        tick();
        FrameStrobe = '0;
        checks++; if (ParityErr !== 1'b1) begin errors++; $display("FAIL parity_set: got %b want 1", ParityErr); end
        Commit = 1;
        tick();
        Commit = 0;
        checks++; if (ConfigBits !== 12'h000) begin errors++; $display("FAIL parity_commit_blocked: got %h want 000", ConfigBits); end
        // Clear coinciding with a fresh parity error keeps the flag.
        ClrErr = 1; FrameStrobe = 20'h00001;
        tick();
        FrameStrobe = '0;
        checks++; if (ParityErr !== 1'b1) begin errors++; $display("FAIL parity_err_wins: got %b want 1", ParityErr); end
        tick();
        ClrErr = 0;
        checks++; if (ParityErr !== 1'b0) begin errors++; $display("FAIL parity_clear: got %b want 0", ParityErr); end
        Commit = 1;
        tick();
        Commit = 0;
        checks++; if (ConfigBits !== 12'h000) begin errors++; $display("FAIL parity_shadow_kept: got %h want 000", ConfigBits); end
    endtask

    task automatic test_strobe();
        FrameData = 32'hFFF0_0000; FrameParity = 0; FrameStrobe = 20'h00001; Commit = 1;
        tick();
        FrameData = 32'h1230_0000; FrameParity = 0; FrameStrobe = 20'h00001; Commit = 1;
        tick();
        Commit = 0;
        checks++; if (ConfigBits !== 12'hFFF) begin errors++; $display("FAIL strobe_setup: got %h want fff", ConfigBits); end
        FrameData = 32'h4560_0000; FrameParity = 1; FrameStrobe = 20'h00003;
        tick();
        FrameStrobe = '0;
        checks++; if (StrobeErr !== 1'b1) begin errors++; $display("FAIL strobe_multi: got %b want 1", StrobeErr); end
        Commit = 1;
        tick();
        Commit = 0;
        checks++; if (ConfigBits !== 12'hFFF) begin errors++; $display("FAIL strobe_commit_blocked: got %h want fff", ConfigBits); end
        ClrErr = 1;
        tick();
        ClrErr = 0;
        checks++; if (StrobeErr !== 1'b0) begin errors++; $display("FAIL strobe_clear: got %b want 0", StrobeErr); end
        FrameStrobe = 20'h00002;
        tick();
        FrameStrobe = '0;
        checks++; if (StrobeErr !== 1'b0 || ParityErr !== 1'b0) begin errors++; $display("FAIL strobe_unused_frame: got %b%b want 00", StrobeErr, ParityErr); end
        Commit = 1;
        tick();
        Commit = 0;
        checks++; if (ConfigBits !== 12'h123) begin errors++; $display("FAIL strobe_shadow_kept: got %h want 123", ConfigBits); end
    endtask

    task automatic test_back_to_back();
        FrameData = 32'hFFF0_0000; FrameParity = 0; FrameStrobe = 20'h00001;
        tick();
        FrameData = 32'hABC0_0000; FrameParity = 1; FrameStrobe = 20'h00001; Commit = 1;
        tick();
        FrameStrobe = '0;
        checks++; if (ConfigBits !== 12'hFFF) begin errors++; $display("FAIL b2b_pre_write: got %h want fff", ConfigBits); end
        tick();
        Commit = 0;
        checks++; if (ConfigBits !== 12'hABC) begin errors++; $display("FAIL b2b_second: got %h want abc", ConfigBits); end
        checks++; if (ConfigBits_N !== 12'h543) begin errors++; $display("FAIL b2b_cfgn: got %h want 543", ConfigBits_N); end
    endtask

    task automatic test_readback();
        RbReq = 1; RbSel = 5'd0; RbReady = 0;
        tick();
        checks++; if (RbValid !== 1'b1 || RbData !== 32'hABC0_0000) begin errors++; $display("FAIL rb_first: got %b %h want 1 abc00000", RbValid, RbData); end
        // All-ones write: only the mapped top 12 bits may be stored.
        FrameData = 32'hFFFF_FFFF; FrameParity = 0; FrameStrobe = 20'h00001;
        for (int c = 0; c < 4; c++) begin
            tick();
            FrameStrobe = '0;
            checks++; if (RbValid !== 1'b1 || RbData !== 32'hABC0_0000) begin errors++; $display("FAIL rb_hold: cycle %0d got %b %h want 1 abc00000", c, RbValid, RbData); end
        end
        RbReq = 0; RbReady = 1;
        tick();
        RbReady = 0;
        checks++; if (RbValid !== 1'b0) begin errors++; $display("FAIL rb_accept: got %b want 0", RbValid); end
        RbReq = 1;
        tick();
        RbReq = 0;
        checks++; if (RbValid !== 1'b1 || RbData !== 32'hFFF0_0000) begin errors++; $display("FAIL rb_masked: got %b %h want 1 fff00000", RbValid, RbData); end
        RbReady = 1;
        tick();
        RbReady = 0;
        RbReq = 1; RbSel = 5'd5;
        tick();
        RbReq = 0;
        checks++; if (RbValid !== 1'b1 || RbData !== 32'h0) begin errors++; $display("FAIL rb_unused_sel: got %b %h want 1 0", RbValid, RbData); end
        RbReady = 1;
        tick();
        RbReady = 0; RbSel = 5'd0;
    endtask

    task automatic test_reset_valid();
        RbReq = 1;
        tick();
        RbReq = 0;
        checks++; if (RbValid !== 1'b1 || ConfigBits !== 12'hABC) begin errors++; $display("FAIL rstv_setup: got %b %h want 1 abc", RbValid, ConfigBits); end
        RST = 1; Commit = 1; RbReady = 0; RbReq = 1;
        FrameData = 32'h1230_0000; FrameParity = 0; FrameStrobe = 20'h00001;
        tick();
        idleInputs();
        checks++; if (RbValid !== 1'b0 || RbData !== 32'h0) begin errors++; $display("FAIL rstv_rb: got %b %h want 0 0", RbValid, RbData); end
        checks++; if (ConfigBits !== 12'h000 || ConfigBits_N !== 12'hFFF) begin errors++; $display("FAIL rstv_cfg: got %h %h want 000 fff", ConfigBits, ConfigBits_N); end
        Commit = 1;
        tick();
        Commit = 0;
        checks++; if (ConfigBits !== 12'h000) begin errors++; $display("FAIL rstv_shadow: got %h want 000", ConfigBits); end
    endtask

    initial begin
        idleInputs();
        test_reset();
        test_write_commit();
        test_parity();
        test_strobe();
        test_back_to_back();
        test_readback();
        test_reset_valid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
